csr_responder: RTL and testbench

//  CSR-side responder for the 3-stage RV32I pipeline. Executes the CSR write/set/clear commands

---
 rtl/csr_responder.sv | 133 +++++++++++++
 tb/tb_csr_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/csr_responder.sv
// csr_responder: CSR write/set/clear responder holding tohost, mscratch and the cycle/instret counters
//
// Executes CSRRW/CSRRS/CSRRC (register and immediate forms) issued by the
// decode/control stage and returns the pre-write value of the addressed CSR
// for rd writeback. Writes take effect on the clock edge that commits them.
//
// Optional feature macro: CSR_COUNTER_EN
//   defined   : 64-bit cycle/instret counters are built and readable at
//               0xC00/0xC80 (cycle lo/hi) and 0xC02/0xC82 (instret lo/hi).
//   undefined : counters are removed, those addresses read 0, stay
//               read-only, and instr_valid is ignored.
//
// Ports
//   clk          in   1     rising-edge clock
//   rst          in   1     synchronous reset, active-low
//   csr_we       in   1     CSR instruction in execute stage
//   csr_sel      in   1     1 = source is rs1_data, 0 = zero-extended zimm
//   funct3       in   3     x01 RW, x10 RS, x11 RC, x00 no-op
//   csr_addr     in   12    CSR address (instruction[31:20])
//   rs1_data     in   XLEN  forwarded rs1 value
//   zimm         in   5     immediate source (instruction[19:15])
//   instr_valid  in   1     an instruction retires this cycle
//   stall        in   1     pipeline stall; blocks commits and instret
//   csr_rdata    out  XLEN  old value of the addressed CSR (combinational)
//   tohost       out  XLEN  current tohost register
//   tohost_valid out  1     one-cycle pulse after a committed tohost write
//   csr_illegal  out  1     one-cycle pulse after a write to a read-only or
//                           unimplemented CSR
module csr_responder #(
    parameter int unsigned XLEN        = 32,
    parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_we,
    input  logic            csr_sel,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      zimm,
    input  logic            instr_valid,
    input  logic            stall,
    output logic [XLEN-1:0] csr_rdata,
    output logic [XLEN-1:0] tohost,
    output logic            tohost_valid,
    output logic            csr_illegal
);
    localparam logic [11:0] MSCRATCH_ADDR = 12'h340;
    localparam logic [11:0] CYCLE_ADDR    = 12'hC00;
    localparam logic [11:0] CYCLEH_ADDR   = 12'hC80;
    localparam logic [11:0] INSTRET_ADDR  = 12'hC02;
    localparam logic [11:0] INSTRETH_ADDR = 12'hC82;
    logic [XLEN-1:0] tohost_q, tohost_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic            tohost_valid_q, tohost_valid_d;
    logic            csr_illegal_q, csr_illegal_d;
    logic            commit, suppress, do_write;
    logic            hit_tohost, hit_mscratch, writable;
    logic [XLEN-1:0] src, old_val, new_val;
    assign commit       = csr_we & ~stall & rst;
    assign src          = csr_sel ? rs1_data : XLEN'(zimm);
    assign hit_tohost   = csr_addr == TOHOST_ADDR;
    assign hit_mscratch = csr_addr == MSCRATCH_ADDR;
    assign writable     = hit_tohost | hit_mscratch;
    // Set/clear with a zero source is a pure read: no state change, no flag.
    assign suppress     = funct3[1] & (src == '0);
    assign do_write     = commit & (funct3[1:0] != 2'b00) & ~suppress;
`ifdef CSR_COUNTER_EN
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;
    // Full 64-bit adds keep the low/high halves consistent on carry.
    assign cycle_d   = cycle_q + 64'd1;
    assign instret_d = instret_q + {63'd0, instr_valid & ~stall};
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end
`else
    logic unused_instr_valid;
    assign unused_instr_valid = instr_valid;
`endif
    always_comb begin
        old_val = '0;
        case (csr_addr)
            TOHOST_ADDR:   old_val = tohost_q;
            MSCRATCH_ADDR: old_val = mscratch_q;
`ifdef CSR_COUNTER_EN
            CYCLE_ADDR:    old_val = XLEN'(cycle_q[31:0]);
            CYCLEH_ADDR:   old_val = XLEN'(cycle_q[63:32]);
            INSTRET_ADDR:  old_val = XLEN'(instret_q[31:0]);
            INSTRETH_ADDR: old_val = XLEN'(instret_q[63:32]);
`endif
            default:       old_val = '0;
        endcase
    end
    always_comb begin
        new_val = old_val;
        case (funct3[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end
    always_comb begin
        tohost_d       = (do_write && hit_tohost) ? new_val : tohost_q;
        mscratch_d     = (do_write && hit_mscratch) ? new_val : mscratch_q;
        tohost_valid_d = do_write & hit_tohost;
        csr_illegal_d  = do_write & ~writable;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            tohost_q       <= '0;
            mscratch_q     <= '0;
            tohost_valid_q <= 1'b0;
            csr_illegal_q  <= 1'b0;
        end else begin
            tohost_q       <= tohost_d;
            mscratch_q     <= mscratch_d;
            tohost_valid_q <= tohost_valid_d;
            csr_illegal_q  <= csr_illegal_d;
        end
    end
    assign csr_rdata    = rst ? old_val : '0;
    assign tohost       = tohost_q;
    assign tohost_valid = tohost_valid_q;
    assign csr_illegal  = csr_illegal_q;
endmodule

// File: tb/tb_csr_responder.sv
// tb_csr_responder: table-driven directed bench for csr_responder
module tb_csr_responder;
    logic        clk = 1'b0;
    logic        rst, csr_we, csr_sel, instr_valid, stall;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic [31:0] csr_rdata, tohost;
    logic        tohost_valid, csr_illegal;
    int          n_chk = 0;
    int          n_fail = 0;

    csr_responder dut (
        .clk(clk), .rst(rst), .csr_we(csr_we), .csr_sel(csr_sel), .funct3(funct3),
        .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm), .instr_valid(instr_valid),
        .stall(stall), .csr_rdata(csr_rdata), .tohost(tohost), .tohost_valid(tohost_valid),
        .csr_illegal(csr_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        sel;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic [31:0] exp_rd;
        logic [31:0] exp_tohost;
        logic        exp_valid;
        logic        exp_ill;
    } vec_t;

    vec_t tbl[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_csr(input logic [11:0] a, input string name, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(name, csr_rdata, exp);
    endtask

    initial begin
        tbl[0]  = '{0, 1, 3'b001, 12'h51E, 32'h1,        5'h00, 32'h0,        32'h1,        1, 0};
        tbl[1]  = '{0, 1, 3'b001, 12'h51E, 32'h1,        5'h00, 32'h1,        32'h1,        1, 0};
        tbl[2]  = '{0, 0, 3'b110, 12'h51E, 32'h0,        5'h00, 32'h1,        32'h1,        0, 0};
        tbl[3]  = '{0, 1, 3'b001, 12'h340, 32'hF0F0F0F0, 5'h00, 32'h0,        32'h1,        0, 0};
        tbl[4]  = '{0, 0, 3'b111, 12'h340, 32'h0,        5'h10, 32'hF0F0F0F0, 32'h1,        0, 0};
        tbl[5]  = '{0, 1, 3'b010, 12'h340, 32'h0,        5'h00, 32'hF0F0F0E0, 32'h1,        0, 0};
        tbl[6]  = '{0, 0, 3'b110, 12'h340, 32'h0,        5'h0F, 32'hF0F0F0E0, 32'h1,        0, 0};
        tbl[7]  = '{0, 1, 3'b001, 12'h340, 32'h0,        5'h00, 32'hF0F0F0EF, 32'h1,        0, 0};
        tbl[8]  = '{0, 1, 3'b000, 12'h340, 32'h5,        5'h00, 32'h0,        32'h1,        0, 0};
        tbl[9]  = '{0, 1, 3'b001, 12'h123, 32'h7,        5'h00, 32'h0,        32'h1,        0, 1};
        tbl[10] = '{0, 0, 3'b011, 12'h123, 32'h0,        5'h00, 32'h0,        32'h1,        0, 0};
        tbl[11] = '{0, 1, 3'b011, 12'h123, 32'h1,        5'h00, 32'h0,        32'h1,        0, 1};
        tbl[12] = '{0, 0, 3'b101, 12'h51E, 32'h0,        5'h1F, 32'h1,        32'h1F,       1, 0};
        tbl[13] = '{0, 1, 3'b100, 12'h51E, 32'hFF,       5'h00, 32'h1F,       32'h1F,       0, 0};
        tbl[14] = '{0, 1, 3'b011, 12'h51E, 32'h0F,       5'h00, 32'h1F,       32'h10,       1, 0};
        tbl[15] = '{1, 1, 3'b001, 12'h51E, 32'hAA,       5'h00, 32'h10,       32'h10,       0, 0};
        tbl[16] = '{1, 1, 3'b001, 12'h123, 32'hAA,       5'h00, 32'h0,        32'h10,       0, 0};
        tbl[17] = '{0, 1, 3'b010, 12'h51E, 32'h80000000, 5'h00, 32'h10,       32'h80000010, 1, 0};

        rst = 1'b0; csr_we = 1'b0; csr_sel = 1'b0; instr_valid = 1'b0; stall = 1'b0;
        funct3 = 3'b000; csr_addr = 12'h51E; rs1_data = '0; zimm = '0;
        tick();
        tick();
        read_csr(12'h51E, "rdata_in_reset", 32'h0);
        rst = 1'b1;
        #1;
        check("reset_tohost", tohost, 32'h0);
        check("reset_valid", {31'd0, tohost_valid}, 32'h0);
        check("reset_illegal", {31'd0, csr_illegal}, 32'h0);
        read_csr(12'h340, "reset_mscratch", 32'h0);
`ifdef CSR_COUNTER_EN
        read_csr(12'hC00, "cycle_after_reset", 32'd0);
        tick();
        read_csr(12'hC00, "cycle_1", 32'd1);
        tick();
        read_csr(12'hC00, "cycle_2", 32'd2);
`endif

        for (int i = 0; i < 18; i++) begin
            csr_we = 1'b1; stall = tbl[i].stall; csr_sel = tbl[i].sel; funct3 = tbl[i].f3;
            csr_addr = tbl[i].addr; rs1_data = tbl[i].rs1; zimm = tbl[i].zimm;
            #3;
            check($sformatf("vec%0d_rdata", i), csr_rdata, tbl[i].exp_rd);
            tick();
            check($sformatf("vec%0d_tohost", i), tohost, tbl[i].exp_tohost);
            check($sformatf("vec%0d_valid", i), {31'd0, tohost_valid}, {31'd0, tbl[i].exp_valid});
            check($sformatf("vec%0d_illegal", i), {31'd0, csr_illegal}, {31'd0, tbl[i].exp_ill});
        end
        csr_we = 1'b0; stall = 1'b0;
        tick();
        check("pulse_drops_valid", {31'd0, tohost_valid}, 32'h0);
        check("pulse_drops_illegal", {31'd0, csr_illegal}, 32'h0);
        read_csr(12'h340, "mscratch_final", 32'h0);

        csr_we = 1'b1; csr_sel = 1'b1; funct3 = 3'b001; csr_addr = 12'h51E; rs1_data = 32'h99;
        tick();
        check("pre_reset_valid", {31'd0, tohost_valid}, 32'h1);
        check("pre_reset_tohost", tohost, 32'h99);
        rst = 1'b0; csr_addr = 12'h340; rs1_data = 32'h1234;
        #3;
        check("reset_rdata_forced", csr_rdata, 32'h0);
        tick();
        check("reset_clears_valid", {31'd0, tohost_valid}, 32'h0);
        check("reset_clears_tohost", tohost, 32'h0);
        rst = 1'b1; csr_we = 1'b0;
        read_csr(12'h340, "reset_commit_dropped", 32'h0);

`ifdef CSR_COUNTER_EN
        read_csr(12'hC00, "cycle_restart_0", 32'd0);
        tick();
        tick();
        tick();
        read_csr(12'hC00, "cycle_restart_3", 32'd3);
        csr_we = 1'b1; funct3 = 3'b001; rs1_data = 32'hFFFF;
        #1;
        check("cycle_write_old", csr_rdata, 32'd3);
        tick();
        check("cycle_write_illegal", {31'd0, csr_illegal}, 32'h1);
        csr_we = 1'b0;
        read_csr(12'hC00, "cycle_unchanged_counts", 32'd4);
        for (int k = 0; k < 10; k++) begin
            instr_valid = 1'b1;
            stall = (k == 2 || k == 5 || k == 8);
            tick();
        end
        instr_valid = 1'b0; stall = 1'b0;
        read_csr(12'hC02, "instret_7", 32'd7);
        read_csr(12'hC82, "instreth_0", 32'd0);
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        read_csr(12'hC00, "cycle_forced_lo", 32'hFFFFFFFF);
        tick();
        read_csr(12'hC00, "cycle_carry_lo", 32'h0);
        read_csr(12'hC80, "cycle_carry_hi", 32'h1);
        force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        tick();
        read_csr(12'hC00, "cycle_wrap_lo", 32'h0);
        read_csr(12'hC80, "cycle_wrap_hi", 32'h0);
`else
        instr_valid = 1'b1;
        tick();
        tick();
        tick();
        instr_valid = 1'b0;
        read_csr(12'hC00, "nocnt_cycle", 32'h0);
        read_csr(12'hC80, "nocnt_cycleh", 32'h0);
        read_csr(12'hC02, "nocnt_instret", 32'h0);
        read_csr(12'hC82, "nocnt_instreth", 32'h0);
        csr_we = 1'b1; csr_sel = 1'b1; funct3 = 3'b001; rs1_data = 32'h5;
        tick();
        check("nocnt_write_illegal", {31'd0, csr_illegal}, 32'h1);
        csr_we = 1'b0;
        read_csr(12'hC02, "nocnt_instret_after", 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
